// File: rtl/program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_memory_loader
// Description : Boot loader. Packs a valid/ready byte stream little-endian
//               into 32-bit instruction words, writes each word into program
//               memory and holds the core in reset until the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module program_memory_loader #(
    parameter int          PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS         = 32'h0040_0000,
    parameter int          CNT_W                = $clog2(PROGRAM_MEMORY_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             mem_write_o,
    output logic [31:0]      mem_address_o,
    output logic [31:0]      mem_data_o,
    output logic             core_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PROGRAM_MEMORY_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [2:0]       state;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] last_idx;
    logic [31:0]      word_sr;
    logic             idle_like;

    // A new load can only be requested when no load is in flight.
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

    // Loader FSM, byte packing and word indexing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            byte_cnt <= 2'd0;
            word_idx <= '0;
            last_idx <= '0;
            word_sr  <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        if (num_words_i == '0) begin
                            state <= S_DONE;
                        end else if (num_words_i > DEPTH_C) begin
                            state <= S_ERROR;
                        end else begin
                            state    <= S_COLLECT;
                            word_idx <= '0;
                            byte_cnt <= 2'd0;
                            last_idx <= num_words_i - ONE_C;
                        end
                    end
                end
                S_COLLECT: begin
                    if (byte_valid_i) begin
                        // First byte of a word is the least significant one.
                        word_sr[{byte_cnt, 3'b000} +: 8] <= byte_data_i;
                        byte_cnt                         <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (word_idx == last_idx) begin
                        state <= S_DONE;
                    end else begin
                        word_idx <= word_idx + ONE_C;
                        state    <= S_COLLECT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so the write strobe, address and
    // data are all stable for the whole WRITE cycle.
    assign byte_ready_o  = (state == S_COLLECT);
    assign mem_write_o   = (state == S_WRITE);
    assign mem_address_o = BASE_ADDRESS + {{(30 - CNT_W){1'b0}}, word_idx, 2'b00};
    assign mem_data_o    = word_sr;
    assign busy_o        = (state == S_COLLECT) || (state == S_WRITE);
    assign core_reset_o  = (state != S_DONE);
    assign done_o        = (state == S_DONE);
    assign error_o       = (state == S_ERROR);

    // idle_like documents the start-acceptance condition used in the FSM.
    logic unused_ok;
    assign unused_ok = idle_like;

endmodule
`default_nettype wire
